// File: rtl/data_mem_responder_pkg.sv
// Memory-map constants and shared types for the CPU data-memory responder.
// The top-level parameters default to these values.
package data_mem_responder_pkg;

  localparam logic [31:0] STATIC_BASE  = 32'h1000_0000;
  localparam logic [31:0] DYNAMIC_BASE = 32'h1000_8000;
  localparam int          WINDOW_BYTES = 1024;
  localparam int          WINDOW_WORDS = WINDOW_BYTES / 4;
  localparam int          INDEX_BITS   = $clog2(WINDOW_WORDS);
  localparam int          WAIT_STATES  = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Which bank (if any) sources the load data of the held response.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_STATIC,
    SEL_DYNAMIC
  } sel_e;

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed data bank: one synchronous read/write port with byte enables.
// Read data stays in its output register until the next read.
module dmem_bank #(
  parameter int Words     = 256,
  parameter int IndexBits = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 we,
  input  logic [IndexBits-1:0] index,
  input  logic [31:0]          wdata,
  input  logic [3:0]           be,
  output logic [31:0]          rdata
);

  logic [31:0] mem_q [Words];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    // NOTE: default assigned first so no path leaves rdata_d unassigned (no latch).
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[index];
    end
  end

  // NOTE: the storage array has no reset; clearing RAM costs a write port per word.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU load/store interface: decodes the static and dynamic
// data windows, performs the access after WaitStates cycles, holds the response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter logic [31:0] StaticBase  = STATIC_BASE,
  parameter logic [31:0] DynamicBase = DYNAMIC_BASE,
  parameter int          WindowBytes = WINDOW_BYTES,
  parameter int          WaitStates  = WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         Words    = WindowBytes / 4;
  localparam int         IdxBits  = $clog2(Words);
  localparam logic [3:0] WaitLoad = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;
  sel_e        sel_q, sel_d;
  logic        enter_resp;

  logic               cur_we;
  logic [31:0]        cur_addr, cur_wdata;
  logic [3:0]         cur_be;
  logic [31:0]        off_stat, off_dyn;
  logic               hit_stat, hit_dyn, cur_err;
  sel_e               cur_sel;
  logic [IdxBits-1:0] cur_idx;

  logic        bank_stat_en, bank_dyn_en;
  logic [31:0] bank_stat_rdata, bank_dyn_rdata;

  // With zero wait states the access commits on the accept edge, straight from the inputs.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    off_stat = cur_addr - StaticBase;
    off_dyn  = cur_addr - DynamicBase;
    hit_stat = (cur_addr >= StaticBase)  && (off_stat < 32'(WindowBytes));
    hit_dyn  = (cur_addr >= DynamicBase) && (off_dyn  < 32'(WindowBytes));
    cur_err  = !(hit_stat || hit_dyn) || (cur_addr[1:0] != 2'b00);
    cur_sel  = hit_stat ? SEL_STATIC : (hit_dyn ? SEL_DYNAMIC : SEL_NONE);
    cur_idx  = hit_stat ? off_stat[IdxBits+1:2] : off_dyn[IdxBits+1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    err_d      = err_q;
    sel_d      = sel_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WaitStates == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = WaitLoad;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d = cur_err;
      sel_d = (cur_err || cur_we) ? SEL_NONE : cur_sel;
    end
  end

  // Reset wins over the commit edge, so a store still in WAIT is never written.
  assign bank_stat_en = enter_resp && !rst && !cur_err && (cur_sel == SEL_STATIC);
  assign bank_dyn_en  = enter_resp && !rst && !cur_err && (cur_sel == SEL_DYNAMIC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      sel_q   <= SEL_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

  dmem_bank #(.Words(Words), .IndexBits(IdxBits)) u_bank_static (
    .clk   (clk),
    .rst   (rst),
    .en    (bank_stat_en),
    .we    (cur_we),
    .index (cur_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (bank_stat_rdata)
  );

  dmem_bank #(.Words(Words), .IndexBits(IdxBits)) u_bank_dynamic (
    .clk   (clk),
    .rst   (rst),
    .en    (bank_dyn_en),
    .we    (cur_we),
    .index (cur_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (bank_dyn_rdata)
  );

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;

  always_comb begin
    resp_rdata = '0;
    if (resp_valid) begin
      case (sel_q)
        SEL_STATIC:  resp_rdata = bank_stat_rdata;
        SEL_DYNAMIC: resp_rdata = bank_dyn_rdata;
        default:     resp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: four responders with different wait-state counts, directed
// corner cases plus random traffic checked against a word-level memory model.
module tb_data_mem_responder;

  localparam int NDUT = 4;

  function automatic int ws_of(int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 0;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_we     [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic [3:0]  req_be     [NDUT];
  logic        resp_valid [NDUT];
  logic        resp_ready [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_responder #(.WaitStates(ws_of(g))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per-DUT word contents plus a mask of lanes that have ever been written.
  logic [31:0] model_mem [longint];
  logic [3:0]  model_vld [longint];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_access(input int d, input bit we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] be,
                                       output bit err, output logic [31:0] rdata,
                                       output bit known);
    bit          in_s, in_d;
    longint      key;
    logic [31:0] word;
    logic [3:0]  vld;
    in_s  = (addr >= 32'h1000_0000) && (addr <= 32'h1000_03FF);
    in_d  = (addr >= 32'h1000_8000) && (addr <= 32'h1000_83FF);
    err   = !(in_s || in_d) || (addr % 4 != 0);
    rdata = '0;
    known = 1'b1;
    if (!err) begin
      key = (longint'(d) << 32) | longint'(addr);
      if (!model_mem.exists(key)) begin
        model_mem[key] = '0;
        model_vld[key] = '0;
      end
      word = model_mem[key];
      vld  = model_vld[key];
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            word[8*i +: 8] = wdata[8*i +: 8];
            vld[i]         = 1'b1;
          end
        end
        model_mem[key] = word;
        model_vld[key] = vld;
      end else begin
        rdata = word;
        known = (vld == 4'hF);
      end
    end
  endfunction

  task automatic idle_inputs(input int d);
    req_valid[d]  = 1'b0;
    req_we[d]     = 1'b0;
    req_addr[d]   = '0;
    req_wdata[d]  = '0;
    req_be[d]     = '0;
    resp_ready[d] = 1'b0;
  endtask

  task automatic drive_req(input int d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_txn(input int d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold,
                         input string tag, output logic [31:0] got_rdata, output bit got_err);
    bit          exp_err, known;
    logic [31:0] exp_rdata, first;
    int          n;
    n = 0;
    while (!req_ready[d] && n < 8) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    drive_req(d, we, addr, wdata, be);
    model_access(d, we, addr, wdata, be, exp_err, exp_rdata, known);
    @(posedge clk); @(negedge clk);
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      check({tag, "_busy_ready"}, 32'(req_ready[d]), 32'd0);
      // Junk on the request side while busy must be ignored.
      drive_req(d, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      @(posedge clk); @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(ws_of(d) + 1));
    first     = resp_rdata[d];
    got_rdata = first;
    got_err   = resp_err[d];
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    if (known) check({tag, "_rdata"}, got_rdata, exp_rdata);
    for (int h = 0; h < hold; h++) begin
      drive_req(d, 1'b1, $urandom, $urandom, 4'($urandom));
      @(posedge clk); @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid[d]), 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata[d], first);
      check({tag, "_hold_ready"}, 32'(req_ready[d]), 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready[d] = 1'b0;
    check({tag, "_done_valid"}, 32'(resp_valid[d]), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  // Accepts a request, then asserts rst for one cycle rst_at cycles after accept.
  task automatic abort_txn(input int d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int rst_at, input bit commits, input string tag);
    bit          e;
    bit          k;
    logic [31:0] r;
    int          n;
    check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    drive_req(d, we, addr, wdata, be);
    if (commits) model_access(d, we, addr, wdata, be, e, r, k);
    @(posedge clk); @(negedge clk);
    req_valid[d] = 1'b0;
    n = 1;
    while (n < rst_at) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    check({tag, "_pre_rst_valid"}, 32'(resp_valid[d]), 32'(rst_at >= ws_of(d) + 1));
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check({tag, "_rst_valid"}, 32'(resp_valid[d]), 32'd0);
    check({tag, "_rst_ready"}, 32'(req_ready[d]), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, "_post_rst_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int          kind, r;
    logic [31:0] idx;
    kind = $urandom_range(0, 9);
    r    = $urandom_range(0, 7);
    idx  = (r < 4) ? 32'(r) : 32'(248 + r);
    case (kind)
      0, 1, 2, 3: return 32'h1000_0000 + idx * 4;
      4, 5, 6, 7: return 32'h1000_8000 + idx * 4;
      8: begin
        case ($urandom_range(0, 3))
          0:       return 32'h1000_0400;
          1:       return 32'h1000_4000;
          2:       return 32'h1000_8400;
          default: return 32'h0FFF_FFFC;
        endcase
      end
      default: return 32'h1000_0000 + idx * 4 + 32'($urandom_range(1, 3));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    bit          err;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) idle_inputs(d);
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_ready_%0d", d), 32'(req_ready[d]), 32'd0);
      check($sformatf("rst_valid_%0d", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("rst_rdata_%0d", d), resp_rdata[d], 32'd0);
      check($sformatf("rst_err_%0d", d), 32'(resp_err[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("post_rst_ready_%0d", d), 32'(req_ready[d]), 32'd1);
    end

    // First load and lane merge on the dynamic window.
    run_txn(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, "first_load", got, err);
    run_txn(0, 1'b1, 32'h1000_8000, 32'hDEAD_BEEF, 4'b1111, 0, "st_full", got, err);
    check("st_full_rdata_zero", got, 32'd0);
    run_txn(0, 1'b1, 32'h1000_8000, 32'h0000_00AA, 4'b0001, 0, "st_lane0", got, err);
    run_txn(0, 1'b0, 32'h1000_8000, 32'h0, 4'h0, 0, "ld_merge", got, err);
    check("merge_value", got, 32'hDEAD_BEAA);

    // Window boundaries and misalignment.
    run_txn(0, 1'b0, 32'h1000_03FC, 32'h0, 4'hF, 0, "ld_last", got, err);
    check("last_word_err", 32'(err), 32'd0);
    run_txn(0, 1'b0, 32'h1000_0400, 32'h0, 4'hF, 0, "ld_past_end", got, err);
    check("past_end_err", 32'(err), 32'd1);
    check("past_end_rdata", got, 32'd0);
    run_txn(0, 1'b0, 32'h1000_4000, 32'h0, 4'hF, 0, "ld_gap", got, err);
    check("gap_err", 32'(err), 32'd1);
    run_txn(0, 1'b1, 32'h1000_0000, 32'h1122_3344, 4'hF, 0, "st_base", got, err);
    run_txn(0, 1'b1, 32'h1000_0002, 32'hFFFF_FFFF, 4'hF, 0, "st_misalign", got, err);
    check("misalign_err", 32'(err), 32'd1);
    run_txn(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, "ld_base", got, err);
    check("misalign_no_write", got, 32'h1122_3344);

    // Empty byte-enable store and response back-pressure.
    run_txn(0, 1'b1, 32'h1000_0000, 32'h5555_5555, 4'b0000, 0, "st_no_be", got, err);
    check("no_be_err", 32'(err), 32'd0);
    run_txn(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 5, "ld_backpressure", got, err);
    check("no_be_unchanged", got, 32'h1122_3344);

    // Reset while waiting (store dropped) and while responding (store kept).
    run_txn(1, 1'b1, 32'h1000_8010, 32'hCAFE_F00D, 4'hF, 0, "st_prior", got, err);
    abort_txn(1, 1'b1, 32'h1000_8010, 32'h1234_5678, 4'hF, 3, 1'b0, "rst_in_wait");
    run_txn(1, 1'b0, 32'h1000_8010, 32'h0, 4'hF, 0, "ld_after_wait_rst", got, err);
    check("wait_rst_no_commit", got, 32'hCAFE_F00D);
    run_txn(1, 1'b1, 32'h1000_8014, 32'h0000_0000, 4'hF, 0, "st_clear", got, err);
    abort_txn(1, 1'b1, 32'h1000_8014, 32'h0BAD_F00D, 4'hF, 4, 1'b1, "rst_in_resp");
    run_txn(1, 1'b0, 32'h1000_8014, 32'h0, 4'hF, 0, "ld_after_resp_rst", got, err);
    check("resp_rst_committed", got, 32'h0BAD_F00D);

    // Extreme wait-state counts: loads and stores both checked for latency.
    for (int d = 2; d < NDUT; d++) begin
      run_txn(d, 1'b1, 32'h1000_0004, 32'hA5A5_5A5A, 4'hF, 1, $sformatf("sweep_st_%0d", d), got, err);
      run_txn(d, 1'b0, 32'h1000_0004, 32'h0, 4'hF, 1, $sformatf("sweep_ld_%0d", d), got, err);
      check($sformatf("sweep_val_%0d", d), got, 32'hA5A5_5A5A);
    end

    // Random traffic on every instance.
    for (int d = 0; d < NDUT; d++) begin
      for (int t = 0; t < 40; t++) begin
        run_txn(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom),
                $urandom_range(0, 3), $sformatf("rnd_%0d_%0d", d, t), got, err);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
